// File: rtl/stopwatch_ctrl_lap.sv
// stopwatch_ctrl_lap: IDLE/RUNNING/PAUSED run control with a tick prescaler,
// a CNT_W-bit elapsed counter and a first-word-fall-through lap FIFO.
// Optional build macro: OVERFLOW_SAT_EN makes elapsed saturate at all-ones
// (the overflowing tick holds the value and forces PAUSED). When the macro is
// undefined, elapsed wraps to 0.
module stopwatch_ctrl_lap #(
   parameter int CNT_W     = 16,
   parameter int PRESCALE  = 100000,
   parameter int LAP_DEPTH = 4,
   parameter int LAP_AW    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              pause,
   input  logic              clear,
   input  logic              lap,
   input  logic              lap_rd,
   output logic              enable,
   output logic [1:0]        state,
   output logic              tick,
   output logic [CNT_W-1:0]  elapsed,
   output logic              lap_valid,
   output logic [CNT_W-1:0]  lap_data,
   output logic [LAP_AW:0]   lap_count,
   output logic              lap_overflow
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUNNING = 2'b01,
      PAUSED  = 2'b10,
      ILLEGAL = 2'b11
   } state_t;

   localparam int                PW      = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]     PRE_MAX = PW'(PRESCALE - 1);
   localparam logic [LAP_AW:0]   DEPTH_C = (LAP_AW + 1)'(LAP_DEPTH);

   state_t              state_q, state_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic [CNT_W-1:0]    elapsed_q, elapsed_d;

   logic [CNT_W-1:0]    lap_mem_q [LAP_DEPTH];
   logic [LAP_AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [LAP_AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LAP_AW:0]     count_q, count_d;
   logic                ovf_q, ovf_d;

   logic wipe, running, tick_w;
   logic push_req, push, pop, full;

   // An illegal state encoding is recovered exactly like a clear command.
   assign wipe    = clear || (state_q == ILLEGAL);
   assign running = (state_q == RUNNING);
   assign tick_w  = running && (presc_q == PRE_MAX);

   // Laps are taken only while a measurement is live; a coincident clear wins.
   assign push_req = lap && !wipe && ((state_q == RUNNING) || (state_q == PAUSED));
   assign pop      = lap_rd && (count_q != '0) && !wipe;
   assign full     = (count_q == DEPTH_C);
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push     = push_req && (!full || pop);

   // Run-control next state, prescaler and elapsed counter.
   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      elapsed_d = elapsed_q;
      if (wipe) begin
         state_d   = IDLE;
         presc_d   = '0;
         elapsed_d = '0;
      end else begin
         case (state_q)
            IDLE:    if (start) state_d = RUNNING;
            RUNNING: if (pause) state_d = PAUSED;
            PAUSED:  if (start) state_d = RUNNING;
            default: state_d = IDLE;
         endcase
         // The prescaler only moves while running, so a resume continues the
         // partial period; a tick in a pause cycle still counts.
         if (running) begin
            if (tick_w) begin
               presc_d = '0;
`ifdef OVERFLOW_SAT_EN
               if (&elapsed_q) state_d = PAUSED;
               else            elapsed_d = elapsed_q + CNT_W'(1);
`else
               elapsed_d = elapsed_q + CNT_W'(1);
`endif
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
      end
   end

   // Lap FIFO pointers, occupancy and sticky overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (wipe) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + LAP_AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + LAP_AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + (LAP_AW + 1)'(1);
            2'b01:   count_d = count_q - (LAP_AW + 1)'(1);
            default: count_d = count_q;
         endcase
         if (push_req && full && !pop) ovf_d = 1'b1;
      end
   end

   // Control and FIFO bookkeeping registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         elapsed_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         elapsed_q <= elapsed_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
      end
   end

   // Lap storage; contents are only visible through lap_data when non-empty.
   always_ff @(posedge clk) begin
      if (push) lap_mem_q[wr_ptr_q] <= elapsed_q;
   end

   assign state        = state_q;
   assign enable       = running;
   assign tick         = tick_w;
   assign elapsed      = elapsed_q;
   assign lap_valid    = (count_q != '0);
   assign lap_data     = lap_valid ? lap_mem_q[rd_ptr_q] : '0;
   assign lap_count    = count_q;
   assign lap_overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl_lap.sv
// Bench for stopwatch_ctrl_lap with CNT_W=4, PRESCALE=4, LAP_DEPTH=2.
// Outputs are packed as {state,enable,tick,elapsed,lap_valid,lap_data,
// lap_count,lap_overflow}; expectations are queued when a cycle's stimulus is
// driven and compared on that cycle's falling edge.
module tb_stopwatch_ctrl_lap;

   logic       clk = 1'b0, rst = 1'b0;
   logic       start = 1'b0, pause = 1'b0, clear = 1'b0, lap = 1'b0, lap_rd = 1'b0;
   logic       enable, tick, lap_valid, lap_overflow;
   logic [1:0] state, lap_count;
   logic [3:0] elapsed, lap_data;

   localparam logic [15:0] FM = 16'hFFFF;

   stopwatch_ctrl_lap #(.CNT_W(4), .PRESCALE(4), .LAP_DEPTH(2), .LAP_AW(1)) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
      .lap(lap), .lap_rd(lap_rd), .enable(enable), .state(state), .tick(tick),
      .elapsed(elapsed), .lap_valid(lap_valid), .lap_data(lap_data),
      .lap_count(lap_count), .lap_overflow(lap_overflow)
   );

   always #5 clk = ~clk;

   typedef struct { string nm; logic [15:0] exp; logic [15:0] mask; } sb_t;
   typedef struct { logic s, p, c, l, r; logic [15:0] exp; } vec_t;

   sb_t  sb_q[$];
   vec_t vt[28];
   int   n_pass = 0, n_tot = 0;

   function automatic logic [15:0] mk(input logic [1:0] st, input logic en, input logic tk,
                                      input logic [3:0] el, input logic lv, input logic [3:0] ld,
                                      input logic [1:0] lc, input logic ov);
      return {st, en, tk, el, lv, ld, lc, ov};
   endfunction

   function automatic logic [15:0] obs();
      return {state, enable, tick, elapsed, lap_valid, lap_data, lap_count, lap_overflow};
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp,
                      input logic [15:0] mask);
      n_tot++;
      if ((act & mask) === (exp & mask)) n_pass++;
      else $display("FAIL %s: got %h expected %h (mask %h)", nm, act, exp, mask);
   endtask

   // One clock cycle of stimulus; a non-zero mask queues an expectation.
   task automatic cyc(input logic s, input logic p, input logic c, input logic l,
                      input logic r, input string nm = "", input logic [15:0] e = '0,
                      input logic [15:0] m = '0);
      sb_t x;
      @(posedge clk);
      #1;
      start = s; pause = p; clear = c; lap = l; lap_rd = r;
      if (m != '0) begin
         x.nm = nm; x.exp = e; x.mask = m;
         sb_q.push_back(x);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 0, 0, 0);
   endtask

   // Scoreboard: compare the queued expectation for this cycle.
   always @(negedge clk) begin : sb_chk
      sb_t x;
      if (sb_q.size() != 0) begin
         x = sb_q.pop_front();
         chk(x.nm, obs(), x.exp, x.mask);
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // start/resume/pause timing plus ignored commands
      vt[0]  = '{1, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0)};  // start + lap in IDLE
      vt[1]  = '{0, 0, 0, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0)};
      vt[2]  = '{0, 0, 0, 0, 1, mk(1, 1, 0, 0, 0, 0, 0, 0)};  // lap_rd on empty
      vt[3]  = '{0, 0, 0, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0)};
      vt[4]  = '{0, 0, 0, 0, 0, mk(1, 1, 1, 0, 0, 0, 0, 0)};
      vt[5]  = '{1, 0, 0, 0, 0, mk(1, 1, 0, 1, 0, 0, 0, 0)};  // start while running
      vt[6]  = '{0, 0, 0, 0, 0, mk(1, 1, 0, 1, 0, 0, 0, 0)};
      vt[7]  = '{0, 0, 0, 0, 0, mk(1, 1, 0, 1, 0, 0, 0, 0)};
      vt[8]  = '{0, 0, 0, 0, 0, mk(1, 1, 1, 1, 0, 0, 0, 0)};
      vt[9]  = '{0, 0, 0, 0, 0, mk(1, 1, 0, 2, 0, 0, 0, 0)};
      vt[10] = '{0, 0, 0, 0, 0, mk(1, 1, 0, 2, 0, 0, 0, 0)};
      vt[11] = '{0, 0, 0, 0, 0, mk(1, 1, 0, 2, 0, 0, 0, 0)};
      vt[12] = '{0, 0, 0, 0, 0, mk(1, 1, 1, 2, 0, 0, 0, 0)};
      vt[13] = '{0, 0, 0, 0, 0, mk(1, 1, 0, 3, 0, 0, 0, 0)};
      vt[14] = '{0, 1, 0, 0, 0, mk(1, 1, 0, 3, 0, 0, 0, 0)};  // pause, prescaler -> 2
      for (int i = 15; i <= 23; i++) vt[i] = '{0, 0, 0, 0, 0, mk(2, 0, 0, 3, 0, 0, 0, 0)};
      vt[18].p = 1'b1;                                        // pause while paused
      vt[24] = '{1, 0, 0, 0, 0, mk(2, 0, 0, 3, 0, 0, 0, 0)};  // resume
      vt[25] = '{0, 0, 0, 0, 0, mk(1, 1, 0, 3, 0, 0, 0, 0)};
      vt[26] = '{0, 0, 0, 0, 0, mk(1, 1, 1, 3, 0, 0, 0, 0)};
      vt[27] = '{0, 0, 0, 0, 0, mk(1, 1, 0, 4, 0, 0, 0, 0)};

      // power-on reset state
      #3;
      chk("reset_state", obs(), '0, FM);
      @(posedge clk);
      #3 rst = 1'b1;

      for (int i = 0; i < 28; i++)
         cyc(vt[i].s, vt[i].p, vt[i].c, vt[i].l, vt[i].r, $sformatf("vec%0d", i), vt[i].exp, FM);

      // laps at elapsed 1,2,3 without reads: third is dropped
      cyc(0, 0, 1, 0, 0, "clr_run",  mk(1, 1, 0, 4, 0, 0, 0, 0), FM);
      cyc(1, 0, 0, 0, 0, "clr_idle", mk(0, 0, 0, 0, 0, 0, 0, 0), FM);
      idle(4);
      cyc(0, 0, 0, 1, 0, "lap1",     mk(1, 1, 0, 1, 0, 0, 0, 0), FM);
      cyc(0, 0, 0, 0, 0, "lap1_in",  mk(1, 1, 0, 1, 1, 1, 1, 0), FM);
      idle(2);
      cyc(0, 0, 0, 1, 0, "lap2",     mk(1, 1, 0, 2, 1, 1, 1, 0), FM);
      cyc(0, 0, 0, 0, 0, "lap2_in",  mk(1, 1, 0, 2, 1, 1, 2, 0), FM);
      idle(2);
      cyc(0, 0, 0, 1, 0, "lap3",     mk(1, 1, 0, 3, 1, 1, 2, 0), FM);
      cyc(0, 0, 0, 0, 1, "ovf_set",  mk(1, 1, 0, 3, 1, 1, 2, 1), FM);
      cyc(0, 0, 0, 0, 0, "rd_head",  mk(1, 1, 0, 3, 1, 2, 1, 1), FM);

      // full FIFO with simultaneous lap and read; then clear + lap
      cyc(0, 0, 1, 0, 0, "clr_tick", mk(1, 1, 1, 3, 1, 2, 1, 1), FM);
      cyc(1, 0, 0, 0, 0, "flushed",  mk(0, 0, 0, 0, 0, 0, 0, 0), FM);
      cyc(0, 0, 0, 1, 0, "lapa",     mk(1, 1, 0, 0, 0, 0, 0, 0), FM);
      cyc(0, 0, 0, 0, 0, "lapa_in",  mk(1, 1, 0, 0, 1, 0, 1, 0), FM);
      idle(2);
      cyc(0, 0, 0, 1, 0, "lapb",     mk(1, 1, 0, 1, 1, 0, 1, 0), FM);
      cyc(0, 0, 0, 0, 0, "full",     mk(1, 1, 0, 1, 1, 0, 2, 0), FM);
      idle(2);
      cyc(0, 0, 0, 1, 1, "lap_rd",   mk(1, 1, 0, 2, 1, 0, 2, 0), FM);
      cyc(0, 0, 0, 0, 1, "head_adv", mk(1, 1, 0, 2, 1, 1, 2, 0), FM);
      cyc(0, 0, 1, 1, 0, "wrap_hd",  mk(1, 1, 0, 2, 1, 2, 1, 0), FM);
      cyc(1, 0, 0, 0, 0, "clr_lap",  mk(0, 0, 0, 0, 0, 0, 0, 0), FM);

      // asynchronous reset while running at elapsed=5
      idle(20);
      cyc(0, 0, 0, 0, 0, "el5",      mk(1, 1, 0, 5, 0, 0, 0, 0), FM);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 chk("async_rst", obs(), '0, FM);
      @(posedge clk);
      #3 rst = 1'b1;

      // run to elapsed=15 and take one more tick
      cyc(1, 0, 0, 0, 0);
      idle(63);
      cyc(0, 0, 0, 0, 0, "el15_tick", mk(1, 1, 1, 15, 0, 0, 0, 0), FM);
`ifdef OVERFLOW_SAT_EN
      cyc(0, 0, 0, 0, 0, "sat_hold",  mk(2, 0, 0, 15, 0, 0, 0, 0), FM);
      cyc(0, 0, 0, 0, 0, "sat_stay",  mk(2, 0, 0, 15, 0, 0, 0, 0), FM);
`else
      cyc(0, 0, 0, 0, 0, "wrap0",     mk(1, 1, 0, 0, 0, 0, 0, 0), FM);
      cyc(0, 0, 0, 0, 0, "wrap_run",  mk(1, 1, 0, 0, 0, 0, 0, 0), FM);
`endif
      @(posedge clk);
      @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl_lap.md
Name: stopwatch_ctrl_lap

Overview:
- Parametrised next-generation stopwatch controller.
- Combines the IDLE/RUNNING/PAUSED run-control FSM with:
  - an internal tick prescaler,
  - a CNT_W-bit elapsed counter,
  - a lap-capture FIFO with first-word-fall-through read handshake.
- Sits between the debounced button inputs and the display/readout logic. Replaces the bare enable-only controller.

Parameters:
CNT_W, 16, width of elapsed counter and lap entries
PRESCALE, 100000, clk cycles per elapsed-count tick (>=2)
LAP_DEPTH, 4, lap FIFO entries (power of 2, >=2)
LAP_AW, 2, log2(LAP_DEPTH)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-low (rst=0 resets; deassertion synchronous to clk externally)
start  in  1  single-cycle pulse: start/resume
pause  in  1  single-cycle pulse: pause
clear  in  1  single-cycle pulse: synchronous clear to IDLE
lap  in  1  single-cycle pulse: capture elapsed into lap FIFO
lap_rd  in  1  pop lap FIFO head (honoured only when lap_valid=1)
enable  out  1  1 iff state==RUNNING
state  out  2  current state encoding
tick  out  1  1-cycle pulse when elapsed increments
elapsed  out  CNT_W  elapsed tick count
lap_valid  out  1  FIFO non-empty
lap_data  out  CNT_W  FIFO head (valid when lap_valid=1)
lap_count  out  LAP_AW+1  FIFO occupancy, 0..LAP_DEPTH
lap_overflow  out  1  sticky: a lap was dropped because FIFO was full

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; prescaler=0; elapsed=0; FIFO empty.
  - All outputs 0.
- States:
  - IDLE=2'b00, RUNNING=2'b01, PAUSED=2'b10.
  - 2'b11 is illegal; it goes to IDLE next cycle and clears elapsed, prescaler and FIFO exactly as clear does.
- Command priority per cycle: clear > pause > start.
- Transitions:
  - IDLE: start -> RUNNING.
  - RUNNING: pause -> PAUSED.
  - PAUSED: start -> RUNNING.
  - clear in any state -> IDLE; zeroes elapsed and prescaler, flushes FIFO, clears lap_overflow.
  - Ignored commands: start in RUNNING, pause in IDLE/PAUSED.
- enable and state are combinational from the state register; enable rises the cycle after the start pulse.
- Prescaler:
  - Counts 0..PRESCALE-1 only while RUNNING.
  - Holds its value in PAUSED, so resume continues the partial period.
  - tick=1 in the cycle the prescaler equals PRESCALE-1 while RUNNING. The prescaler wraps to 0 and elapsed increments at that edge, visible the next cycle.
  - First tick arrives PRESCALE cycles after enable rises.
  - Pause asserted in a tick cycle: the tick still counts and the state moves to PAUSED.
- elapsed wraps from all-ones to 0 (default build).
- Lap capture:
  - lap in RUNNING or PAUSED pushes the current registered elapsed value (the pre-increment value if coincident with tick).
  - lap in IDLE is ignored.
  - lap coincident with clear is discarded.
- FIFO:
  - Full plus lap without lap_rd: entry dropped, lap_overflow set.
  - Full plus lap plus lap_rd: pop and push both occur, count stays LAP_DEPTH, no overflow.
  - Empty plus lap_rd: ignored.
  - Empty plus lap plus lap_rd: push only.
  - lap_data updates the cycle after a pop or after a push into an empty FIFO.
  - Pointers wrap modulo LAP_DEPTH.

Optional Feature:
- OVERFLOW_SAT_EN defined:
  - elapsed saturates at all-ones.
  - A tick that would wrap instead holds the value and forces state to PAUSED at that edge.
  - tick still pulses for that cycle.
- OVERFLOW_SAT_EN undefined: wrap behaviour as above.

Test Plan:
- Bench params: CNT_W=4, PRESCALE=4, LAP_DEPTH=2.
- Scenario 1: rst=0 mid-RUNNING with elapsed=5 -> immediately state=00, elapsed=0, lap_count=0, enable=0, lap_overflow=0.
- Scenario 2: start pulse at cycle 0 -> enable=1 from cycle 1; tick at cycles 4, 8, 12; elapsed=3 at cycle 13.
- Scenario 3: RUNNING with prescaler=2, pause pulse, hold 10 cycles, start pulse -> elapsed unchanged while PAUSED; next tick 2 cycles after enable returns.
- Scenario 4: laps at elapsed=1, 2, 3 with no reads -> lap_count=2, lap_overflow=1; lap_data=1, then 2 after one lap_rd.
- Scenario 5: full FIFO, lap and lap_rd in the same cycle -> lap_count stays 2, lap_overflow stays 0, head advances. Separately, clear and lap in the same cycle -> state=IDLE, lap_count=0.
- Scenario 6: run to elapsed=15, next tick -> default build: elapsed=0, state RUNNING; OVERFLOW_SAT_EN build: elapsed=15, state=PAUSED, enable=0.
